// File: rtl/dot_seq_i8.sv
// -----------------------------------------------------------------------------
// dot_seq_i8 -- sequenced signed dot-product accumulator.
//
// A job is a run of 1..max_blk blocks. Each block is a pair of k-element signed
// vectors. One combinational dot_i8 engine is shared by every block of the job.
// Each accepted block is captured into a stage-1 register pair, and the
// engine's result is added into the job accumulator on the following edge.
//
// Handshakes (both directions are strict valid/ready):
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - A producer holds valid (and its data) stable until the transfer.
//   - Ready never depends combinationally on valid.
//   Input side:  i_valid / o_ready carries i_vec_a + i_vec_b, one block per transfer.
//   Output side: o_valid / i_ready carries o_acc, one result per job.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_n_blk    job start request and block count (sampled in IDLE)
//   i_valid, o_ready    block handshake
//   i_vec_a, i_vec_b    operand blocks, k elements of bit_width bits (signed)
//   o_valid, i_ready    result handshake
//   o_acc               signed accumulated dot product
//   o_busy              high whenever the FSM is not in IDLE
//   o_dbg_state         current FSM state encoding (0 IDLE,1 RUN,2 DRAIN,3 DONE)
// -----------------------------------------------------------------------------

// Combinational k-element signed dot product.
//   i_vec_a, i_vec_b  k elements of bit_width bits, interpreted as signed
//   o_dot             signed sum of element products
module dot_i8 #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int dot_width = 2 * bit_width + $clog2(k)
) (
    input  logic        [k-1:0][bit_width-1:0] i_vec_a,
    input  logic        [k-1:0][bit_width-1:0] i_vec_b,
    output logic signed [dot_width-1:0]        o_dot
);

    logic signed [bit_width-1:0]   elem_a;
    logic signed [bit_width-1:0]   elem_b;
    logic signed [2*bit_width-1:0] prod;

    always_comb begin
        o_dot  = '0;
        elem_a = '0;
        elem_b = '0;
        prod   = '0;
        for (int i = 0; i < k; i++) begin
            elem_a = i_vec_a[i];
            elem_b = i_vec_b[i];
            // Full-width product of two signed elements cannot overflow.
            prod   = elem_a * elem_b;
            o_dot  = o_dot + dot_width'(prod);
        end
    end

endmodule

module dot_seq_i8 #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int max_blk   = 16,
    parameter int dot_width = 2 * bit_width + $clog2(k),
    parameter int acc_width = dot_width + $clog2(max_blk)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic        [$clog2(max_blk+1)-1:0] i_n_blk,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic        [k-1:0][bit_width-1:0]  i_vec_a,
    input  logic        [k-1:0][bit_width-1:0]  i_vec_b,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic signed [acc_width-1:0]         o_acc,
    output logic                                o_busy,
    output logic        [1:0]                   o_dbg_state
);

    localparam int cnt_w = $clog2(max_blk + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [cnt_w-1:0]               n_q, n_d;
    logic [cnt_w-1:0]               cnt_q, cnt_d;
    logic                           s1_v_q, s1_v_d;
    logic                           valid_q, valid_d;
    logic signed [acc_width-1:0]    acc_q, acc_d;
    logic [k-1:0][bit_width-1:0]    vec_a_q;
    logic [k-1:0][bit_width-1:0]    vec_b_q;

    logic                           accept;
    logic [cnt_w-1:0]               n_clamped;
    logic [cnt_w-1:0]               cnt_inc;
    logic signed [dot_width-1:0]    dot;

    // Single shared engine; it always sees the stage-1 block.
    dot_i8 #(
        .bit_width (bit_width),
        .k         (k),
        .dot_width (dot_width)
    ) u_dot (
        .i_vec_a (vec_a_q),
        .i_vec_b (vec_b_q),
        .o_dot   (dot)
    );

    // Ready comes straight from the state register.
    assign o_ready     = (state_q == S_RUN);
    assign accept      = i_valid && o_ready;
    assign n_clamped   = (i_n_blk > cnt_w'(max_blk)) ? cnt_w'(max_blk) : i_n_blk;
    assign cnt_inc     = cnt_q + cnt_w'(1);

    assign o_valid     = valid_q;
    assign o_acc       = acc_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        s1_v_d  = accept;
        acc_d   = acc_q;
        valid_d = 1'b0;

        // The stage-1 block lands in the accumulator one edge after capture.
        if (s1_v_q) begin
            acc_d = acc_q + acc_width'(dot);
        end
        if (accept) begin
            cnt_d = cnt_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d = '0;
                    if (n_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_clamped;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept && (cnt_inc == n_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last block's accumulate happens on this cycle's edge.
                state_d = S_DONE;
            end
            S_DONE: begin
                // o_valid is a flop: it rises on the cycle after DONE is
                // entered, when o_acc has already been stable for a cycle.
                valid_d = 1'b1;
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            s1_v_q  <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            s1_v_q  <= s1_v_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
        end
    end

    // Stage-1 operand registers, loaded only on a transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vec_a_q <= '0;
            vec_b_q <= '0;
        end else if (accept) begin
            vec_a_q <= i_vec_a;
            vec_b_q <= i_vec_b;
        end
    end

endmodule

// File: tb/tb_dot_seq_i8.sv
module tb_dot_seq_i8;

  localparam int BW    = 8;
  localparam int K     = 32;
  localparam int MAXB  = 16;
  localparam int NW    = $clog2(MAXB + 1);
  localparam int ACC_W = 2 * BW + $clog2(K) + $clog2(MAXB);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // DUT signals
  logic                     i_start = 1'b0;
  logic [NW-1:0]            i_n_blk = '0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic [K-1:0][BW-1:0]     i_vec_a = '0;
  logic [K-1:0][BW-1:0]     i_vec_b = '0;
  logic                     o_valid;
  logic                     i_ready = 1'b0;
  logic signed [ACC_W-1:0]  o_acc;
  logic                     o_busy;
  logic [1:0]               o_dbg_state;

  dot_seq_i8 dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_n_blk     (i_n_blk),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_vec_a     (i_vec_a),
    .i_vec_b     (i_vec_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_acc       (o_acc),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fill(input int a, input int b);
    for (int i = 0; i < K; i++) begin
      i_vec_a[i] = a[BW-1:0];
      i_vec_b[i] = b[BW-1:0];
    end
  endtask

  // Runs one job. Block j carries all elements a = a_base + a_inc*j, b = b_val.
  task automatic run_job(input string tag, input int n_req, input int a_base,
                         input int a_inc, input int b_val, input int gap,
                         input int exp_accepts, input longint exp_acc,
                         input bit chk_lat, input bit hold);
    int blk, gap_cnt, accepts, budget, last_edge, ready_bad;
    bit acc_now;
    logic signed [63:0] want;
    exp_q.push_back(exp_acc);
    @(negedge clk);
    check({tag, "_ready_idle"}, o_ready, 0);
    i_start = 1'b1;
    i_n_blk = NW'(n_req);
    @(negedge clk);
    i_start = 1'b0;
    blk = 0; gap_cnt = 0; accepts = 0; budget = 500; last_edge = 0; ready_bad = 0;
    while (!o_valid && budget > 0) begin
      // once every expected block is in, o_ready must stay low (DRAIN/DONE)
      if (accepts == exp_accepts && o_ready) ready_bad++;
      if (blk < n_req && gap_cnt == 0) begin
        i_valid = 1'b1;
        fill(a_base + a_inc * blk, b_val);
      end else begin
        i_valid = 1'b0;
      end
      acc_now = i_valid && o_ready;
      @(negedge clk);
      budget--;
      if (acc_now) begin
        accepts++;
        blk++;
        last_edge = edge_cnt;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
    end
    i_valid = 1'b0;
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_accepts"}, accepts, exp_accepts);
    check({tag, "_ready_outside_run"}, ready_bad, 0);
    if (chk_lat) check({tag, "_latency"}, edge_cnt - last_edge, 2);
    want = exp_q.pop_front();
    check({tag, "_acc"}, o_acc, want);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        i_ready = 1'b0;
        i_start = ~i_start;
        i_n_blk = NW'(3);
        @(negedge clk);
        check({tag, "_hold_valid"}, o_valid, 1);
        check({tag, "_hold_acc"}, o_acc, want);
        check({tag, "_hold_busy"}, o_busy, 1);
      end
      i_start = 1'b0;
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_idle_busy"}, o_busy, 0);
    check({tag, "_idle_valid"}, o_valid, 0);
    check({tag, "_acc_retained"}, o_acc, want);
  endtask

  int r_accepts, r_budget;
  bit r_acc_now;

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_acc", o_acc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    //      tag          n   a   inc  b    gap acc exp_acc   lat hold
    run_job("ones4",     4,  1,  0,   1,    0, 4,  128,      1,  0);
    run_job("neg_neg16", 16, -128, 0, -128, 0, 16, 8388608,  1,  0);
    run_job("neg_pos16", 16, -128, 0, 127,  0, 16, -8323072, 1,  0);
    run_job("gaps3",     3,  1,  1,   1,    2, 3,  192,      1,  0);
    run_job("zero",      0,  1,  0,   1,    0, 0,  0,        0,  0);
    run_job("clamp20",   20, 1,  0,   1,    0, 16, 512,      1,  0);
    run_job("hold",      2,  -1, 0,   1,    0, 2,  -64,      1,  1);

    // reset after the 2nd of 4 blocks
    @(negedge clk);
    i_start = 1'b1;
    i_n_blk = NW'(4);
    @(negedge clk);
    i_start = 1'b0;
    r_accepts = 0;
    r_budget = 50;
    while (r_accepts < 2 && r_budget > 0) begin
      i_valid = 1'b1;
      fill(5, 5);
      r_acc_now = o_ready;
      @(negedge clk);
      if (r_acc_now) r_accepts++;
      r_budget--;
    end
    i_valid = 1'b0;
    check("mid_accepts", r_accepts, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_acc", o_acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", o_valid, 0);
      check("post_rst_busy", o_busy, 0);
    end
    run_job("after_rst", 2, 3, 0, -2, 0, 2, -384, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
